// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: key sequencer for the stopwatch datapath.
// Drives run/clear, keeps a small lap buffer and picks the display value.
module stop_watch_ctrl #(
    parameter int          LAP_DEPTH = 4,
    parameter logic [23:0] MAX_NUM   = 24'h995999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  model,
    input  logic        key_ss,
    input  logic        key_lr,
    input  logic        key_rcl,
    input  logic [23:0] sw_num,
    output logic        pause,
    output logic        clear,
    output logic [23:0] disp_num,
    output logic [2:0]  lap_cnt,
    output logic [2:0]  rcl_idx,
    output logic        run_led
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SPLIT,
        STOP,
        RECALL
    } state_t;

    localparam logic [2:0] DEPTH = 3'(LAP_DEPTH);

    state_t      state;
    state_t      ret_state;
    logic [23:0] split_q;
    // Eight slots so a 3-bit index is always in range; only the first
    // LAP_DEPTH are ever written, the rest stay zero.
    logic [23:0] lap [8];

    logic active;
    logic ss;
    logic lr;
    logic rcl;
    logic at_max;

    // Mode gating and key priority: ss over lr over rcl.
    always_comb begin
        active = (model == 2'b10);
        ss     = active & key_ss;
        lr     = active & key_lr & ~key_ss;
        rcl    = active & key_rcl & ~key_ss & ~key_lr;
        at_max = (state == RUN || state == SPLIT) && (sw_num == MAX_NUM);
    end

    // Sequencer, lap buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            pause     <= 1'b0;
            run_led   <= 1'b0;
            clear     <= 1'b0;
            disp_num  <= '0;
            lap_cnt   <= '0;
            rcl_idx   <= '0;
            split_q   <= '0;
            for (int i = 0; i < 8; i++) lap[i] <= '0;
        end else begin
            clear <= 1'b0;

            case (state)
                SPLIT:   disp_num <= split_q;
                RECALL:  disp_num <= lap[rcl_idx];
                default: disp_num <= sw_num;
            endcase

            if (at_max) begin
                state   <= STOP;
                pause   <= 1'b0;
                run_led <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss) begin
                            state   <= RUN;
                            pause   <= 1'b1;
                            run_led <= 1'b1;
                        end else if (rcl && lap_cnt != 3'd0) begin
                            state     <= RECALL;
                            ret_state <= IDLE;
                            rcl_idx   <= '0;
                        end
                    end
                    RUN: begin
                        if (ss) begin
                            state   <= STOP;
                            pause   <= 1'b0;
                            run_led <= 1'b0;
                        end else if (lr) begin
                            state   <= SPLIT;
                            split_q <= sw_num;
                            if (lap_cnt < DEPTH) begin
                                lap[lap_cnt] <= sw_num;
                                lap_cnt      <= lap_cnt + 3'd1;
                            end
                        end
                    end
                    SPLIT: begin
                        if (ss) begin
                            state   <= STOP;
                            pause   <= 1'b0;
                            run_led <= 1'b0;
                        end else if (lr) begin
                            state <= RUN;
                        end
                    end
                    STOP: begin
                        if (ss) begin
                            state   <= RUN;
                            pause   <= 1'b1;
                            run_led <= 1'b1;
                        end else if (lr) begin
                            state   <= IDLE;
                            clear   <= 1'b1;
                            lap_cnt <= '0;
                            for (int i = 0; i < 8; i++) lap[i] <= '0;
                        end else if (rcl && lap_cnt != 3'd0) begin
                            state     <= RECALL;
                            ret_state <= STOP;
                            rcl_idx   <= '0;
                        end
                    end
                    RECALL: begin
                        if (ss) begin
                            state   <= ret_state;
                            rcl_idx <= '0;
                        end else if (rcl) begin
                            if (rcl_idx == lap_cnt - 3'd1) begin
                                state   <= ret_state;
                                rcl_idx <= '0;
                            end else begin
                                rcl_idx <= rcl_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        pause   <= 1'b0;
                        run_led <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// tb_stop_watch_ctrl: directed bench for stop_watch_ctrl.
// Linear key sequences with hand-computed expectations.
module tb_stop_watch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  model;
    logic        key_ss;
    logic        key_lr;
    logic        key_rcl;
    logic [23:0] sw_num;
    logic        pause;
    logic        clear;
    logic [23:0] disp_num;
    logic [2:0]  lap_cnt;
    logic [2:0]  rcl_idx;
    logic        run_led;

    int total = 0;
    int bad   = 0;

    stop_watch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .model    (model),
        .key_ss   (key_ss),
        .key_lr   (key_lr),
        .key_rcl  (key_rcl),
        .sw_num   (sw_num),
        .pause    (pause),
        .clear    (clear),
        .disp_num (disp_num),
        .lap_cnt  (lap_cnt),
        .rcl_idx  (rcl_idx),
        .run_led  (run_led)
    );

    always #5 clk = ~clk;

    // One edge, then settle; keys are single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        key_ss  = 1'b0;
        key_lr  = 1'b0;
        key_rcl = 1'b0;
    endtask

    task automatic chk(input string tag,
                       input logic [23:0] obs,
                       input logic [23:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        model   = 2'b10;
        key_ss  = 1'b1;
        key_lr  = 1'b0;
        key_rcl = 1'b0;
        sw_num  = 24'h0;
        tick();
        rst = 1'b0;
        chk("rst_pause", pause, 0);
        chk("rst_clear", clear, 0);
        chk("rst_led", run_led, 0);
        chk("rst_disp", disp_num, 0);
        chk("rst_lap", lap_cnt, 0);
        chk("rst_rcl", rcl_idx, 0);

        // start / stop / restart
        key_ss = 1'b1; tick();
        chk("ss_run_pause", pause, 1);
        chk("ss_run_led", run_led, 1);
        key_ss = 1'b1; tick();
        chk("ss_stop_pause", pause, 0);
        key_ss = 1'b1; tick();
        chk("ss_rerun", pause, 1);

        // split capture and release
        sw_num = 24'h001234;
        key_lr = 1'b1; tick();
        chk("split_lap", lap_cnt, 1);
        chk("split_pause", pause, 1);
        sw_num = 24'h001300; tick();
        chk("split_disp0", disp_num, 24'h001234);
        sw_num = 24'h001301; tick();
        chk("split_disp1", disp_num, 24'h001234);
        sw_num = 24'h001302;
        key_lr = 1'b1; tick();
        chk("unsplit_disp_lag", disp_num, 24'h001234);
        sw_num = 24'h001400; tick();
        chk("unsplit_live", disp_num, 24'h001400);
        chk("unsplit_lap", lap_cnt, 1);

        // laps 2..4, then a 5th that is dropped
        sw_num = 24'h000002; key_lr = 1'b1; tick();
        key_lr = 1'b1; tick();
        sw_num = 24'h000003; key_lr = 1'b1; tick();
        key_lr = 1'b1; tick();
        sw_num = 24'h000004; key_lr = 1'b1; tick();
        chk("lap4", lap_cnt, 4);
        key_lr = 1'b1; tick();
        sw_num = 24'h000005; key_lr = 1'b1; tick();
        chk("lap_sat", lap_cnt, 4);
        chk("lap_sat_split", pause, 1);
        key_ss = 1'b1; tick();
        chk("lap_stop", pause, 0);

        // recall walk
        key_rcl = 1'b1; tick();
        chk("rcl_entry", rcl_idx, 0);
        tick();
        chk("rcl_d0", disp_num, 24'h001234);
        key_rcl = 1'b1; tick();
        chk("rcl_i1", rcl_idx, 1);
        tick();
        chk("rcl_d1", disp_num, 24'h000002);
        key_rcl = 1'b1; tick();
        tick();
        chk("rcl_d2", disp_num, 24'h000003);
        key_rcl = 1'b1; tick();
        chk("rcl_i3", rcl_idx, 3);
        tick();
        chk("rcl_d3", disp_num, 24'h000004);
        key_rcl = 1'b1; tick();
        chk("rcl_exit_idx", rcl_idx, 0);
        chk("rcl_exit_pause", pause, 0);
        tick();
        chk("rcl_exit_disp", disp_num, 24'h000005);

        // STOP -> IDLE clear
        key_lr = 1'b1; tick();
        chk("clr_pulse", clear, 1);
        chk("clr_lap", lap_cnt, 0);
        sw_num = 24'h0; tick();
        chk("clr_one", clear, 0);
        tick();
        chk("clr_disp", disp_num, 0);
        sw_num = 24'h000777;
        key_rcl = 1'b1; tick();
        chk("idle_rcl_idx", rcl_idx, 0);
        tick();
        chk("idle_rcl_disp", disp_num, 24'h000777);

        // auto-stop at MAX_NUM
        key_ss = 1'b1; tick();
        chk("max_run", pause, 1);
        sw_num = 24'h995999; tick();
        chk("max_pause", pause, 0);
        chk("max_led", run_led, 0);
        key_lr = 1'b1; tick();
        chk("max_stop_state", clear, 1);
        sw_num = 24'h0; tick();

        // priority: ss + lr in RUN
        key_ss = 1'b1; tick();
        sw_num = 24'h000111;
        key_ss = 1'b1; key_lr = 1'b1; tick();
        chk("prio_pause", pause, 0);
        chk("prio_lap", lap_cnt, 0);
        key_rcl = 1'b1; tick();
        chk("prio_rcl0", rcl_idx, 0);

        // mode gating
        model = 2'b01;
        key_ss = 1'b1; tick();
        chk("gate_ss", pause, 0);
        key_lr = 1'b1; tick();
        chk("gate_lr", clear, 0);
        model = 2'b10;
        key_ss = 1'b1; tick();
        model = 2'b01;
        key_ss = 1'b1; tick();
        chk("gate_run_hold", pause, 1);
        model = 2'b10;

        // reset mid-SPLIT
        sw_num = 24'h000222;
        key_lr = 1'b1; tick();
        chk("rst_split_lap", lap_cnt, 1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst2_pause", pause, 0);
        chk("rst2_led", run_led, 0);
        chk("rst2_lap", lap_cnt, 0);
        chk("rst2_disp", disp_num, 0);
        chk("rst2_clear", clear, 0);
        tick();
        chk("rst2_noclr", clear, 0);
        chk("rst2_live", disp_num, 24'h000222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
